// File: rtl/data_deserialiser_pkg.sv
// Shared encodings and helpers for the serial-to-parallel write-back path.
// Used by the deserialiser and by the load-path sign extender.
package data_deserialiser_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Reserved encoding 2'b11 behaves as a word.
    function automatic int unsigned item_bits(input logic [1:0] size);
        int unsigned bits;
        case (size)
            SIZE_BYTE: bits = 8;
            SIZE_HALF: bits = 16;
            default:   bits = 32;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/data_deserialiser_sign_extender.sv
// Widens a byte/half/word item to the full word, sign or zero filled.
// Purely combinational so the load path can share it.
module sign_extender
    import data_deserialiser_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] raw,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    output logic [WORD_WIDTH-1:0] ext
);

    int unsigned bits;
    logic        msb;

    always_comb begin
        bits = item_bits(size);
        case (size)
            SIZE_BYTE: msb = raw[7];
            SIZE_HALF: msb = raw[15];
            default:   msb = raw[31];
        endcase
        for (int i = 0; i < WORD_WIDTH; i++) begin
            ext[i] = (i < bits) ? raw[i] : (sign_ext & msb);
        end
    end

endmodule

// File: rtl/data_deserialiser.sv
// Bit-serial (LSB-first) to parallel converter feeding register write-back.
// Collects byte/half/word items and hands them over with valid/ready.
module data_deserialiser
    import data_deserialiser_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             size,
    input  logic                   sign_ext,
    input  logic                   in_valid,
    input  logic [DIGIT_WIDTH-1:0] serial_in,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  word_out
);

    localparam int CW = $clog2(WORD_WIDTH / DIGIT_WIDTH) + 1;

    state_t                state;
    state_t                state_nxt;
    logic [WORD_WIDTH-1:0] sr;
    logic [WORD_WIDTH-1:0] sr_nxt;
    logic [WORD_WIDTH-1:0] raw;
    logic [WORD_WIDTH-1:0] ext;
    logic [WORD_WIDTH-1:0] word_q;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         last_idx;
    logic [1:0]            size_q;
    logic                  sext_q;
    logic                  take;
    logic                  last;
    logic                  load;

    assign take     = (state == ST_SHIFT) && in_valid;
    assign last_idx = CW'(item_bits(size_q) / DIGIT_WIDTH - 1);
    assign last     = take && (cnt == last_idx);
    assign load     = start && ((state == ST_IDLE) ||
                                (state == ST_DONE && out_ready));

    // New digits enter at the top, so a short item ends up left-aligned.
    assign sr_nxt = {serial_in, sr[WORD_WIDTH-1:DIGIT_WIDTH]};
    assign raw    = sr_nxt >> (WORD_WIDTH - item_bits(size_q));

    sign_extender #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_sign_extender (
        .raw      (raw),
        .size     (size_q),
        .sign_ext (sext_q),
        .ext      (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last) state_nxt = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = start ? ST_SHIFT : ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_SHIFT);
        busy      = (state != ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr     <= '0;
            cnt    <= '0;
            size_q <= SIZE_BYTE;
            sext_q <= 1'b0;
            word_q <= '0;
        end else begin
            if (load) begin
                size_q <= size;
                sext_q <= sign_ext;
                cnt    <= '0;
            end
            if (take) begin
                sr  <= sr_nxt;
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                word_q <= ext;
            end
        end
    end

    assign word_out = word_q;

endmodule

// File: tb/tb_data_deserialiser.sv
// Directed bench for data_deserialiser: 1-bit and 4-bit digit instances.
// Expected words and latencies are hand-computed constants.
module tb_data_deserialiser;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sign_ext, in_valid, serial_in, out_ready;
    logic [1:0]  size;
    logic        in_ready, busy, out_valid;
    logic [31:0] word_out;

    logic        n_start, n_sign_ext, n_in_valid, n_out_ready;
    logic [1:0]  n_size;
    logic [3:0]  n_serial_in;
    logic        n_in_ready, n_busy, n_out_valid;
    logic [31:0] n_word_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_deserialiser #(.WORD_WIDTH(32), .DIGIT_WIDTH(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size      (size),
        .sign_ext  (sign_ext),
        .in_valid  (in_valid),
        .serial_in (serial_in),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_out  (word_out)
    );

    data_deserialiser #(.WORD_WIDTH(32), .DIGIT_WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (n_start),
        .size      (n_size),
        .sign_ext  (n_sign_ext),
        .in_valid  (n_in_valid),
        .serial_in (n_serial_in),
        .in_ready  (n_in_ready),
        .busy      (n_busy),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .word_out  (n_word_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n digits LSB-first; a stall of gap_len cycles precedes digit gap_pos.
    task automatic shift_digits(input logic [31:0] data, input int n,
                                input int gap_pos, input int gap_len,
                                inout int lat);
        for (int i = 0; i < n; i++) begin
            if (i == gap_pos) begin
                in_valid = 1'b0;
                repeat (gap_len) begin
                    tick();
                    lat++;
                end
            end
            if (i == n - 1) check("no_early_valid", {31'b0, out_valid}, 32'd0);
            in_valid  = 1'b1;
            serial_in = data[i];
            tick();
            lat++;
        end
        in_valid  = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic do_item(input logic [1:0] sz, input logic se,
                           input logic [31:0] data, input int gap_pos,
                           input int gap_len, output int lat);
        int n;
        n = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        start    = 1'b1;
        size     = sz;
        sign_ext = se;
        tick();
        start = 1'b0;
        lat   = 1;
        shift_digits(data, n, gap_pos, gap_len, lat);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        start = 0; size = 0; sign_ext = 0; in_valid = 0;
        serial_in = 0; out_ready = 0;
        n_start = 0; n_size = 0; n_sign_ext = 0; n_in_valid = 0;
        n_serial_in = 0; n_out_ready = 0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_word_out", word_out, 32'd0);
        tick();

        // Gap-free word
        do_item(2'b10, 1'b0, 32'hDEADBEEF, -1, 0, lat);
        check("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check("t1_latency", lat, 33);
        check("t1_word", word_out, 32'hDEADBEEF);
        check("t1_in_ready", {31'b0, in_ready}, 32'd0);
        accept();
        check("t1_idle", {31'b0, busy}, 32'd0);

        // Byte / half-word extension
        do_item(2'b00, 1'b1, 32'h80, -1, 0, lat);
        check("t2_latency_b", lat, 9);
        check("t2_byte_sx", word_out, 32'hFFFFFF80);
        accept();
        do_item(2'b00, 1'b0, 32'h80, -1, 0, lat);
        check("t2_byte_zx", word_out, 32'h00000080);
        accept();
        do_item(2'b01, 1'b1, 32'h8001, -1, 0, lat);
        check("t2_latency_h", lat, 17);
        check("t2_half_sx", word_out, 32'hFFFF8001);
        accept();
        do_item(2'b11, 1'b1, 32'h87654321, -1, 0, lat);
        check("t2_reserved_word", word_out, 32'h87654321);
        accept();

        // Mid-stream stall of 5 cycles
        do_item(2'b10, 1'b0, 32'h12345678, 13, 5, lat);
        check("t3_out_valid", {31'b0, out_valid}, 32'd1);
        check("t3_latency", lat, 38);
        check("t3_word", word_out, 32'h12345678);

        // Held in DONE under back-pressure, then zero-bubble restart
        for (int i = 0; i < 10; i++) begin
            start    = i[0];
            in_valid = ~i[0];
            size     = 2'b00;
            tick();
            check("t4_hold_valid", {31'b0, out_valid}, 32'd1);
            check("t4_hold_word", word_out, 32'h12345678);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        size      = 2'b10;
        sign_ext  = 1'b0;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("t4_b2b_in_ready", {31'b0, in_ready}, 32'd1);
        check("t4_b2b_out_valid", {31'b0, out_valid}, 32'd0);
        lat = 1;
        shift_digits(32'hCAFEF00D, 32, -1, 0, lat);
        check("t4_latency", lat, 33);
        check("t4_word", word_out, 32'hCAFEF00D);
        accept();

        // Reset mid-transfer
        start    = 1'b1;
        size     = 2'b10;
        sign_ext = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid  = 1'b1;
            serial_in = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_out_valid", {31'b0, out_valid}, 32'd0);
        check("t5_in_ready", {31'b0, in_ready}, 32'd0);
        do_item(2'b00, 1'b0, 32'h5A, -1, 0, lat);
        check("t5_latency", lat, 9);
        check("t5_word", word_out, 32'h0000005A);
        accept();

        // 4-bit digits
        n_start    = 1'b1;
        n_size     = 2'b10;
        n_sign_ext = 1'b0;
        tick();
        n_start = 1'b0;
        lat     = 1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            d           = 32'hA5C3E10F;
            n_in_valid  = 1'b1;
            n_serial_in = d[4*i +: 4];
            tick();
            lat++;
        end
        n_in_valid = 1'b0;
        check("t6_out_valid", {31'b0, n_out_valid}, 32'd1);
        check("t6_latency", lat, 9);
        check("t6_word", n_word_out, 32'hA5C3E10F);
        n_out_ready = 1'b1;
        tick();
        n_out_ready = 1'b0;
        check("t6_idle", {31'b0, n_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
